// File: rtl/mipi_rx_pkg.sv
// Shared MIPI RX definitions: lane byte width, default SoT sync byte,
// aligner FSM state encoding and a one-bit-difference helper used by the
// SoT-tolerant search.
package mipi_rx_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] SOT_DEFAULT = 8'hB8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_ERROR  = 2'd3
  } align_state_e;

  // True when a and b differ in exactly one bit position.
  function automatic logic one_bit_diff(input logic [BYTE_W-1:0] a,
                                        input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] x;
    x = a ^ b;
    return (x != '0) && ((x & (x - BYTE_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/mipi_rx_lane_sync.sv
// Per-lane SoT search: forms the 16-bit window {din_i, previous din_i},
// finds the lowest bit offset holding the SoT byte, latches that offset and
// lock, and presents the byte-aligned lane byte for every cycle.
// Optional feature macro: MIPI_ALIGN_SOT_TOLERANT_EN (1-bit-error SoT lock).
// Ports:
//   clk, rst      byte clock, synchronous active-high reset
//   flush_i       clear lock/offset (end of burst)
//   search_i      search enabled this cycle
//   din_i         raw deserialised byte of this lane
//   byte_o        aligned byte (found offset in the lock cycle, latched after)
//   match_o       lane locks in this cycle
//   corr_o        lock in this cycle is a 1-bit-corrected match (macro only)
//   locked_o      lane is locked
module mipi_rx_lane_sync
  import mipi_rx_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SOT_PATTERN = SOT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              search_i,
  input  logic [BYTE_W-1:0] din_i,
  output logic [BYTE_W-1:0] byte_o,
  output logic              match_o,
`ifdef MIPI_ALIGN_SOT_TOLERANT_EN
  output logic              corr_o,
`endif
  output logic              locked_o
);

  logic [BYTE_W-1:0]   prev_q;
  logic                locked_q, locked_d;
  logic [2:0]          offset_q, offset_d;
  logic [2*BYTE_W-1:0] win;
  logic                found;
  logic [2:0]          found_off;
  logic [2:0]          sel_off;
`ifdef MIPI_ALIGN_SOT_TOLERANT_EN
  logic                found_corr;
`endif

  // Older byte sits in the low half because bits arrive LSB first.
  assign win = {din_i, prev_q};

  // Scan from the top offset down so the lowest matching offset is kept.
  always_comb begin
    found     = 1'b0;
    found_off = '0;
    for (int k = BYTE_W - 1; k >= 0; k--) begin
      if (win[k +: BYTE_W] == SOT_PATTERN) begin
        found     = 1'b1;
        found_off = 3'(k);
      end
    end
`ifdef MIPI_ALIGN_SOT_TOLERANT_EN
    // An exact match anywhere in the window beats any corrected match.
    found_corr = 1'b0;
    if (!found) begin
      for (int k = BYTE_W - 1; k >= 0; k--) begin
        if (one_bit_diff(win[k +: BYTE_W], SOT_PATTERN)) begin
          found      = 1'b1;
          found_corr = 1'b1;
          found_off  = 3'(k);
        end
      end
    end
`endif
  end

  assign match_o = search_i & ~locked_q & found;
`ifdef MIPI_ALIGN_SOT_TOLERANT_EN
  assign corr_o  = match_o & found_corr;
`endif

  // In the lock cycle the freshly found offset already yields the SoT byte.
  assign sel_off  = locked_q ? offset_q : found_off;
  assign byte_o   = win[sel_off +: BYTE_W];
  assign locked_o = locked_q;

  always_comb begin
    locked_d = locked_q;
    offset_d = offset_q;
    if (flush_i) begin
      locked_d = 1'b0;
      offset_d = '0;
    end else if (match_o) begin
      locked_d = 1'b1;
      offset_d = found_off;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q   <= '0;
      locked_q <= 1'b0;
      offset_q <= '0;
    end else begin
      prev_q   <= din_i;
      locked_q <= locked_d;
      offset_q <= offset_d;
    end
  end

endmodule

// File: rtl/mipi_rx_multilane_aligner.sv
// Multi-lane MIPI HS receive aligner. Each lane finds its SoT byte and bit
// offset; the top-level FSM checks inter-lane skew and a per-lane delay line
// re-times the lanes so every lane's SoT lands in the same output word.
// Optional feature macro: MIPI_ALIGN_SOT_TOLERANT_EN (adds sot_corr).
// Ports:
//   clk, rst     byte clock, synchronous active-high reset
//   hs_en        HS receive active; low ends the burst
//   din          raw bytes, lane n in [8n+7:8n]
//   dout         aligned word, same lane mapping as din
//   valid        dout holds a valid aligned word
//   lane_locked  per-lane SoT found
//   skew_err     sticky per burst: lanes did not lock within SKEW_MAX
//   sot_corr     sticky per burst: a lane locked on a 1-bit-corrected SoT
module mipi_rx_multilane_aligner
  import mipi_rx_pkg::*;
#(
  parameter int                LANES       = 2,
  parameter int                SKEW_MAX    = 3,
  parameter logic [BYTE_W-1:0] SOT_PATTERN = SOT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hs_en,
  input  logic [BYTE_W*LANES-1:0] din,
  output logic [BYTE_W*LANES-1:0] dout,
  output logic                    valid,
  output logic [LANES-1:0]        lane_locked,
  output logic                    skew_err
`ifdef MIPI_ALIGN_SOT_TOLERANT_EN
  ,
  output logic                    sot_corr
`endif
);

  localparam int CNT_W = 4;
  localparam int DL_N  = (SKEW_MAX > 0) ? SKEW_MAX : 1;
  localparam logic [CNT_W-1:0] SKEW_LIM = CNT_W'(SKEW_MAX);

  align_state_e             state_q, state_d;
  logic [LANES-1:0]         match, locked;
  logic [BYTE_W-1:0]        lane_byte [LANES];
  logic                     search, go_lock, go_err, any_lock, all_lock;
  logic [CNT_W-1:0]         cnt_q, cnt_d, cnt_now;
  logic [CNT_W-1:0]         stamp_q [LANES];
  logic [CNT_W-1:0]         stamp_d [LANES];
  logic [CNT_W-1:0]         dly_q   [LANES];
  logic [CNT_W-1:0]         dly_d   [LANES];
  logic [CNT_W-1:0]         dly_now [LANES];
  logic [CNT_W-1:0]         dly_sel [LANES];
  logic [BYTE_W-1:0]        dl_q    [LANES][DL_N];
  logic [BYTE_W*LANES-1:0]  word, dout_q, dout_d;
  logic                     valid_q, valid_d;
  logic                     skew_err_q, skew_err_d;
`ifdef MIPI_ALIGN_SOT_TOLERANT_EN
  logic [LANES-1:0]         corr;
  logic                     sot_corr_q, sot_corr_d;
`endif

  assign search = hs_en && (state_q == ST_HUNT);

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    mipi_rx_lane_sync #(
      .SOT_PATTERN(SOT_PATTERN)
    ) u_sync (
      .clk      (clk),
      .rst      (rst),
      .flush_i  (~hs_en),
      .search_i (search),
      .din_i    (din[n*BYTE_W +: BYTE_W]),
      .byte_o   (lane_byte[n]),
      .match_o  (match[n]),
`ifdef MIPI_ALIGN_SOT_TOLERANT_EN
      .corr_o   (corr[n]),
`endif
      .locked_o (locked[n])
    );
  end

  assign any_lock = |locked;
  assign all_lock = &(locked | match);
  // Counter reads 0 in the cycle the first lane locks, then counts up.
  assign cnt_now  = any_lock ? cnt_q : '0;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (!hs_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_HUNT;
        ST_HUNT: begin
          if (all_lock && (cnt_now <= SKEW_LIM)) state_d = ST_LOCKED;
          else if (cnt_now > SKEW_LIM)           state_d = ST_ERROR;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    go_lock = search && (state_d == ST_LOCKED);
    go_err  = search && (state_d == ST_ERROR);
    valid_d = hs_en && (go_lock || (state_q == ST_LOCKED));
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!hs_en) begin
      cnt_d = '0;
    end else if (search && (any_lock || (|match)) && (cnt_now != '1)) begin
      cnt_d = cnt_now + CNT_W'(1);
    end

    word = '0;
    for (int n = 0; n < LANES; n++) begin
      // Lanes that locked earlier are held back by how long they waited.
      dly_now[n] = cnt_now - (locked[n] ? stamp_q[n] : cnt_now);
      dly_sel[n] = (state_q == ST_LOCKED) ? dly_q[n] : dly_now[n];
      stamp_d[n] = stamp_q[n];
      dly_d[n]   = dly_q[n];
      if (!hs_en) begin
        stamp_d[n] = '0;
        dly_d[n]   = '0;
      end else begin
        if (search && match[n]) stamp_d[n] = cnt_now;
        if (go_lock)            dly_d[n]   = dly_now[n];
      end
      word[n*BYTE_W +: BYTE_W] = lane_byte[n];
      for (int k = 1; k <= SKEW_MAX; k++) begin
        if (dly_sel[n] == CNT_W'(k)) word[n*BYTE_W +: BYTE_W] = dl_q[n][k-1];
      end
    end

    dout_d     = valid_d ? word : dout_q;
    skew_err_d = hs_en && (skew_err_q || go_err);
`ifdef MIPI_ALIGN_SOT_TOLERANT_EN
    sot_corr_d = hs_en && (sot_corr_q || (|(match & corr)));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      skew_err_q <= 1'b0;
      dout_q     <= '0;
`ifdef MIPI_ALIGN_SOT_TOLERANT_EN
      sot_corr_q <= 1'b0;
`endif
      for (int n = 0; n < LANES; n++) begin
        stamp_q[n] <= '0;
        dly_q[n]   <= '0;
        for (int k = 0; k < DL_N; k++) dl_q[n][k] <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      skew_err_q <= skew_err_d;
      dout_q     <= dout_d;
`ifdef MIPI_ALIGN_SOT_TOLERANT_EN
      sot_corr_q <= sot_corr_d;
`endif
      for (int n = 0; n < LANES; n++) begin
        stamp_q[n] <= stamp_d[n];
        dly_q[n]   <= dly_d[n];
        dl_q[n][0] <= hs_en ? lane_byte[n] : '0;
        for (int k = 1; k < DL_N; k++) dl_q[n][k] <= hs_en ? dl_q[n][k-1] : '0;
      end
    end
  end

  assign dout        = dout_q;
  assign valid       = valid_q;
  assign lane_locked = locked;
  assign skew_err    = skew_err_q;
`ifdef MIPI_ALIGN_SOT_TOLERANT_EN
  assign sot_corr    = sot_corr_q;
`endif

endmodule

// File: tb/tb_mipi_rx_multilane_aligner.sv
// Bench for mipi_rx_multilane_aligner (LANES=4, SKEW_MAX=3). Each lane is
// modelled as a serial bit stream with its SoT placed at a chosen bit
// position; expected words are read straight out of those streams.
module tb_mipi_rx_multilane_aligner;

  localparam int LANES    = 4;
  localparam int SKEW_MAX = 3;
  localparam int L        = 24;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 hs_en;
  logic [8*LANES-1:0]   din;
  logic [8*LANES-1:0]   dout;
  logic                 valid;
  logic [LANES-1:0]     lane_locked;
  logic                 skew_err;
`ifdef MIPI_ALIGN_SOT_TOLERANT_EN
  logic                 sot_corr;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [8*L-1:0]     strm  [LANES];
  int                 s_v   [LANES];
  int                 off_v [LANES];
  logic [7:0]         sot_v [LANES];
  bit                 zero_pay;
  logic [8*LANES-1:0] hold_dout;

  always #5 clk = ~clk;

  mipi_rx_multilane_aligner #(
    .LANES      (LANES),
    .SKEW_MAX   (SKEW_MAX),
    .SOT_PATTERN(8'hB8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hs_en      (hs_en),
    .din        (din),
    .dout       (dout),
    .valid      (valid),
    .lane_locked(lane_locked),
    .skew_err   (skew_err)
`ifdef MIPI_ALIGN_SOT_TOLERANT_EN
    ,
    .sot_corr   (sot_corr)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [8*LANES-1:0] d, input logic h, input logic r);
    @(negedge clk);
    din   = d;
    hs_en = h;
    rst   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_locked"}, 32'(lane_locked), 32'd0);
    check({tag, "_skew_err"}, 32'(skew_err), 32'd0);
    check({tag, "_dout"}, dout, hold_dout);
`ifdef MIPI_ALIGN_SOT_TOLERANT_EN
    check({tag, "_sot_corr"}, 32'(sot_corr), 32'd0);
`endif
  endtask

  // end_mode 0: hs_en dropped after the burst; 1: rst pulsed while active.
  task automatic run_burst(input int nwords, input int end_mode);
    int c [LANES];
    int p [LANES];
    bit corr_lane [LANES];
    int cmin, cmax, err_c, ncyc, lim;
    bit ok;
    logic [8*LANES-1:0] d, exp_w;
    logic [LANES-1:0]   exp_lk;
    cmin = 1 << 20;
    cmax = 0;
    for (int n = 0; n < LANES; n++) begin
      p[n] = 8 * s_v[n] + off_v[n];
      strm[n] = '0;
      strm[n][p[n] +: 8] = sot_v[n];
      if (!zero_pay)
        for (int b = p[n] + 8; b < 8 * L; b++) strm[n][b] = 1'($urandom_range(0, 1));
      corr_lane[n] = (sot_v[n] != 8'hB8);
`ifdef MIPI_ALIGN_SOT_TOLERANT_EN
      c[n] = s_v[n] + 1;
`else
      c[n] = corr_lane[n] ? 1000 : s_v[n] + 1;
`endif
      if (c[n] < cmin) cmin = c[n];
      if (c[n] > cmax) cmax = c[n];
    end
    ok    = (cmax - cmin) <= SKEW_MAX;
    err_c = cmin + SKEW_MAX + 1;
    ncyc  = ok ? cmax + nwords : err_c + 3;
    for (int i = 0; i < ncyc; i++) begin
      for (int n = 0; n < LANES; n++) d[8*n +: 8] = strm[n][8*i +: 8];
      step(d, 1'b1, 1'b0);
      lim = (i < err_c) ? i : err_c;
      for (int n = 0; n < LANES; n++) exp_lk[n] = ok ? (i >= c[n]) : (c[n] <= lim);
      check("lane_locked", 32'(lane_locked), 32'(exp_lk));
      if (ok && i >= cmax) begin
        for (int n = 0; n < LANES; n++) exp_w[8*n +: 8] = strm[n][p[n] + 8*(i - cmax) +: 8];
        hold_dout = exp_w;
      end
      check("valid", 32'(valid), 32'(ok && i >= cmax));
      check("dout", dout, hold_dout);
      check("skew_err", 32'(skew_err), 32'(!ok && i >= err_c));
`ifdef MIPI_ALIGN_SOT_TOLERANT_EN
      begin
        bit ec;
        ec = 1'b0;
        for (int n = 0; n < LANES; n++) if (corr_lane[n] && exp_lk[n]) ec = 1'b1;
        check("sot_corr", 32'(sot_corr), 32'(ec));
      end
`endif
    end
    if (end_mode == 0) begin
      step('0, 1'b0, 1'b0);
      check_idle("hs_drop");
    end else begin
      step('0, 1'b1, 1'b1);
      hold_dout = '0;
      check_idle("rst_pulse");
      step('0, 1'b0, 1'b0);
      check_idle("post_rst");
    end
    step('0, 1'b0, 1'b0);
    check_idle("gap");
  endtask

  initial begin
    din       = '0;
    hs_en     = 1'b0;
    rst       = 1'b1;
    hold_dout = '0;
    zero_pay  = 1'b0;
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    check_idle("reset");
    step('0, 1'b0, 1'b0);
    check_idle("after_reset");

    // All lanes: SoT at bit offset 3, same cycle.
    for (int n = 0; n < LANES; n++) begin
      s_v[n] = 3; off_v[n] = 3; sot_v[n] = 8'hB8;
    end
    run_burst(4, 0);

    // Skews 0,1,2,3 with offsets 0,5,7,2; hs_en drops while locked.
    s_v[0] = 3; s_v[1] = 4; s_v[2] = 5; s_v[3] = 6;
    off_v[0] = 0; off_v[1] = 5; off_v[2] = 7; off_v[3] = 2;
    run_burst(6, 0);

    // Relock at different offsets, then rst while valid.
    for (int n = 0; n < LANES; n++) s_v[n] = 2;
    off_v[0] = 6; off_v[1] = 1; off_v[2] = 4; off_v[3] = 0;
    run_burst(3, 1);

    // Lane 1 arrives 4 cycles late: skew error.
    s_v[0] = 3; s_v[1] = 7; s_v[2] = 3; s_v[3] = 3;
    for (int n = 0; n < LANES; n++) off_v[n] = $urandom_range(0, 7);
    run_burst(1, 0);

    // Single-bit-corrupted SoT (B9) on lane 0.
    for (int n = 0; n < LANES; n++) begin
      s_v[n] = 3; off_v[n] = 2 * n; sot_v[n] = 8'hB8;
    end
    sot_v[0] = 8'hB9;
    zero_pay = 1'b1;
    run_burst(3, 0);
    sot_v[0] = 8'hB8;
    zero_pay = 1'b0;

    // Randomised bursts: random offsets, skews (some past the limit), payload.
    for (int r = 0; r < 24; r++) begin
      int base;
      base = 2 + int'($urandom_range(0, 1));
      for (int n = 0; n < LANES; n++) begin
        s_v[n]   = base + int'($urandom_range(0, (r % 3 == 0) ? 0 : 5));
        off_v[n] = int'($urandom_range(0, 7));
      end
      run_burst(int'($urandom_range(1, 8)), int'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
